// File: rtl/text_console.sv
// Byte-stream terminal controller driving the write port of an 80x30 text RAM.
// Define TEXT_CONSOLE_SCROLL_EN for hardware scroll-up; otherwise row overflow wraps to row 0.
module text_console #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  char_data,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] tram_addr,
  output logic [7:0]  tram_wdata,
  output logic        tram_wenable,
  input  logic [7:0]  tram_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_SCR_RD  = 3'd2,
    S_SCR_WR  = 3'd3,
    S_CLR_ROW = 3'd4,
    S_CLR_ALL = 3'd5
  } state_t;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] COLS12    = 12'(COLS);
  localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [11:0] LAST_MOVE = 12'((ROWS - 1) * COLS - 1);
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^tram_rdata;
`endif

  state_t      r_state, w_state_nx;
  logic [6:0]  r_col, w_col_nx;
  logic [4:0]  r_row, w_row_nx;
  logic [7:0]  r_char, w_char_nx;
  logic [11:0] r_idx, w_idx_nx;
  logic [11:0] w_row_base, w_cur_addr;
  logic        w_adv;

  assign w_row_base = 12'(r_row) * COLS12;
  assign w_cur_addr = w_row_base + {5'd0, r_col};

  // Handshake: a byte transfers on a rising edge where char_valid and char_ready
  // are both high; char_ready is high only in IDLE, so valid elsewhere is ignored.
  assign char_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign dbg_state  = r_state;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= 7'd0;
      r_row   <= 5'd0;
      r_char  <= 8'd0;
      r_idx   <= 12'd0;
    end else begin
      r_state <= w_state_nx;
      r_col   <= w_col_nx;
      r_row   <= w_row_nx;
      r_char  <= w_char_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_col_nx     = r_col;
    w_row_nx     = r_row;
    w_char_nx    = r_char;
    w_idx_nx     = r_idx;
    w_adv        = 1'b0;
    tram_addr    = 12'd0;
    tram_wdata   = 8'd0;
    tram_wenable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (char_valid) begin
          w_char_nx  = char_data;
          w_state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nx = S_IDLE;
        case (r_char)
          8'h0D: w_col_nx = 7'd0;
          8'h0A: begin
            w_col_nx = 7'd0;
            w_adv    = 1'b1;
          end
          8'h08: begin
            if (r_col != 7'd0) begin
              w_col_nx     = r_col - 7'd1;
              tram_wenable = 1'b1;
              tram_addr    = w_cur_addr - 12'd1;
              tram_wdata   = BLANK;
            end
          end
          8'h0C: begin
            w_idx_nx   = 12'd0;
            w_state_nx = S_CLR_ALL;
          end
          default: begin
            tram_wenable = 1'b1;
            tram_addr    = w_cur_addr;
            tram_wdata   = r_char;
            if (r_col == LAST_COL) begin
              w_col_nx = 7'd0;
              w_adv    = 1'b1;
            end else begin
              w_col_nx = r_col + 7'd1;
            end
          end
        endcase
        if (w_adv) begin
          if (r_row == LAST_ROW) begin
            w_idx_nx   = 12'd0;
`ifdef TEXT_CONSOLE_SCROLL_EN
            w_state_nx = S_SCR_RD;
`else
            w_row_nx   = 5'd0;
            w_state_nx = S_CLR_ROW;
`endif
          end else begin
            w_row_nx = r_row + 5'd1;
          end
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      // Each cell moves up one row: read cell i+COLS, write it to cell i next cycle.
      S_SCR_RD: begin
        tram_addr  = r_idx + COLS12;
        w_state_nx = S_SCR_WR;
      end
      S_SCR_WR: begin
        tram_wenable = 1'b1;
        tram_addr    = r_idx;
        tram_wdata   = tram_rdata;
        w_idx_nx     = r_idx + 12'd1;
        w_state_nx   = (r_idx == LAST_MOVE) ? S_CLR_ROW : S_SCR_RD;
      end
`endif
      S_CLR_ROW: begin
        tram_wenable = 1'b1;
        tram_addr    = r_idx;
        tram_wdata   = BLANK;
        if (r_idx == w_row_base + COLS12 - 12'd1) begin
          w_idx_nx   = 12'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_idx_nx = r_idx + 12'd1;
        end
      end
      S_CLR_ALL: begin
        tram_wenable = 1'b1;
        tram_addr    = r_idx;
        tram_wdata   = BLANK;
        if (r_idx == LAST_CELL) begin
          w_idx_nx   = 12'd0;
          w_col_nx   = 7'd0;
          w_row_nx   = 5'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_idx_nx = r_idx + 12'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: RAM model, reference terminal model, scenario tasks.
// Expected scroll behaviour follows TEXT_CONSOLE_SCROLL_EN when it is defined.
module tb_text_console;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] tram_addr;
  logic [7:0]  tram_wdata;
  logic        tram_wenable;
  logic [7:0]  tram_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  text_console dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .tram_addr(tram_addr), .tram_wdata(tram_wdata), .tram_wenable(tram_wenable),
    .tram_rdata(tram_rdata), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  // Text RAM: synchronous write, registered read; bd_mode loads fixed patterns.
  logic [7:0] mem [0:2399];
  int bd_mode  = 0;
  int wr_count = 0;
  always @(posedge sys_clk) begin
    if (bd_mode == 1) begin
      for (int i = 0; i < 2400; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (bd_mode == 2) begin
      for (int i = 0; i < 2400; i++) mem[i] <= 8'(i / 80 + 1);
    end else if (tram_wenable && tram_addr < 12'd2400) begin
      mem[tram_addr] <= tram_wdata;
    end
    tram_rdata <= (tram_addr < 12'd2400) ? mem[tram_addr] : 8'h00;
    if (tram_wenable) wr_count <= wr_count + 1;
  end

  // Reference terminal: screen as a flat array plus a cursor.
  logic [7:0] model_mem [0:2399];
  int model_col = 0;
  int model_row = 0;

  function automatic void model_advance_row();
    if (model_row < 29) begin
      model_row++;
    end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      for (int i = 0; i < 29 * 80; i++) model_mem[i] = model_mem[i + 80];
      for (int c = 0; c < 80; c++) model_mem[29 * 80 + c] = 8'h20;
      model_row = 29;
`else
      for (int c = 0; c < 80; c++) model_mem[c] = 8'h20;
      model_row = 0;
`endif
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    case (b)
      8'h0D: model_col = 0;
      8'h0A: begin model_col = 0; model_advance_row(); end
      8'h08: if (model_col > 0) begin
        model_col--;
        model_mem[model_row * 80 + model_col] = 8'h20;
      end
      8'h0C: begin
        for (int i = 0; i < 2400; i++) model_mem[i] = 8'h20;
        model_col = 0;
        model_row = 0;
      end
      default: begin
        model_mem[model_row * 80 + model_col] = b;
        model_col++;
        if (model_col == 80) begin model_col = 0; model_advance_row(); end
      end
    endcase
  endfunction

  function automatic int ram_diffs(output int first);
    int d = 0;
    first = -1;
    for (int i = 0; i < 2400; i++)
      if (mem[i] !== model_mem[i]) begin
        if (first < 0) first = i;
        d++;
      end
    return d;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge, i.e. during EXEC.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    char_data  = b;
    char_valid = 1'b1;
    while (!char_ready && n < 6000) begin step(); n++; end
    if (!char_ready) begin
      checks++; failures++;
      $display("FAIL handshake_timeout ready=%b required=1", char_ready);
    end
    step();
    char_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    step();
    while (busy && n < 6000) begin n++; step(); end
    if (busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    char_valid = 1'b0;
    char_data  = 8'h00;
    rst_n      = 1'b0;
    bd_mode    = 1;
    for (int i = 0; i < 2400; i++) model_mem[i] = 8'(i * 7 + 3);
    step();
    bd_mode = 0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (char_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", char_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tram_wenable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", tram_wenable); end
    checks++; if (tram_addr !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", tram_addr); end
    checks++; if (tram_wdata !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=00", tram_wdata); end
    checks++; if ({cursor_row, cursor_col} !== 12'd0) begin failures++; $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); end
  endtask

  task automatic test_glyph();
    int n, w0;
    w0 = wr_count;
    send_byte(8'h41);
    checks++; if ({tram_wenable, tram_addr, tram_wdata} !== {1'b1, 12'd0, 8'h41}) begin
      failures++; $display("FAIL glyph_write got=we%b a%0d d%h exp=we1 a0 d41", tram_wenable, tram_addr, tram_wdata); end
    checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL glyph_exec_ready got=%b exp=0", char_ready); end
    wait_idle(n);
    checks++; if (char_ready !== 1'b1 || n != 0) begin failures++; $display("FAIL glyph_ready got=%b extra=%0d exp=1 0", char_ready, n); end
    checks++; if ({cursor_row, cursor_col} !== {5'd0, 7'd1}) begin failures++; $display("FAIL glyph_cursor got=(%0d,%0d) exp=(0,1)", cursor_row, cursor_col); end
    checks++; if (wr_count - w0 != 1) begin failures++; $display("FAIL glyph_wrcount got=%0d exp=1", wr_count - w0); end
  endtask

  task automatic test_row_fill();
    int n, nmax, w0, first, d;
    send_byte(8'h0D);
    wait_idle(n);
    w0 = wr_count;
    nmax = 0;
    for (int k = 0; k < 80; k++) begin
      send_byte(8'h42);
      wait_idle(n);
      if (n > nmax) nmax = n;
    end
    checks++; if ({cursor_row, cursor_col} !== {5'd1, 7'd0}) begin failures++; $display("FAIL fill_cursor got=(%0d,%0d) exp=(1,0)", cursor_row, cursor_col); end
    checks++; if (wr_count - w0 != 80 || nmax != 0) begin failures++; $display("FAIL fill_writes got=%0d busy_extra=%0d exp=80 0", wr_count - w0, nmax); end
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL fill_ram diffs=%0d first=%0d got=%h exp=%h", d, first, mem[first], model_mem[first]); end
  endtask

  task automatic test_clear();
    int n, bad, first, d;
    send_byte(8'h0C);
    checks++; if (tram_wenable !== 1'b0) begin failures++; $display("FAIL clear_exec_we got=%b exp=0", tram_wenable); end
    n = 0;
    bad = 0;
    step();
    while (busy && n < 3000) begin
      if (!(tram_wenable === 1'b1 && tram_addr === 12'(n) && tram_wdata === 8'h20)) bad++;
      n++;
      step();
    end
    checks++; if (n != 2400 || bad != 0) begin failures++; $display("FAIL clear_seq cycles=%0d bad=%0d exp=2400 0", n, bad); end
    checks++; if ({busy, cursor_row, cursor_col} !== 13'd0) begin failures++; $display("FAIL clear_end busy=%b cursor=(%0d,%0d) exp=0 (0,0)", busy, cursor_row, cursor_col); end
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL clear_ram diffs=%0d first=%0d", d, first); end
  endtask

  task automatic test_backspace();
    int n, first, d;
    for (int k = 0; k < 5; k++) begin send_byte(8'h30 + 8'(k)); wait_idle(n); end
    send_byte(8'h08);
    checks++; if ({tram_wenable, tram_addr, tram_wdata} !== {1'b1, 12'd4, 8'h20}) begin
      failures++; $display("FAIL bs_write got=we%b a%0d d%h exp=we1 a4 d20", tram_wenable, tram_addr, tram_wdata); end
    wait_idle(n);
    checks++; if ({cursor_row, cursor_col} !== {5'd0, 7'd4}) begin failures++; $display("FAIL bs_cursor got=(%0d,%0d) exp=(0,4)", cursor_row, cursor_col); end
    send_byte(8'h0D);
    wait_idle(n);
    send_byte(8'h08);
    checks++; if (tram_wenable !== 1'b0) begin failures++; $display("FAIL bs_col0_we got=%b exp=0", tram_wenable); end
    wait_idle(n);
    checks++; if ({cursor_row, cursor_col} !== 12'd0) begin failures++; $display("FAIL bs_col0_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); end
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL bs_ram diffs=%0d first=%0d", d, first); end
  endtask

  task automatic test_back_to_back();
    int n, t, first_t, last_t, w0;
    send_byte(8'h0D);
    wait_idle(n);
    w0 = wr_count;
    t = 0;
    first_t = -1;
    last_t = 0;
    char_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      char_data = 8'h61 + 8'(k);
      n = 0;
      while (!char_ready && n < 50) begin step(); t++; n++; end
      if (first_t < 0) first_t = t;
      last_t = t;
      step();
      t++;
      model_byte(8'h61 + 8'(k));
    end
    char_valid = 1'b0;
    wait_idle(n);
    checks++; if (last_t - first_t != 18) begin failures++; $display("FAIL b2b_rate got=%0d exp=18", last_t - first_t); end
    checks++; if (wr_count - w0 != 10) begin failures++; $display("FAIL b2b_writes got=%0d exp=10", wr_count - w0); end
    checks++; if ({cursor_row, cursor_col} !== {5'(model_row), 7'(model_col)}) begin
      failures++; $display("FAIL b2b_cursor got=(%0d,%0d) exp=(%0d,%0d)", cursor_row, cursor_col, model_row, model_col); end
  endtask

  task automatic test_scroll();
    int n, exp_n, first, d;
    send_byte(8'h0D);
    wait_idle(n);
    while (model_row < 29) begin send_byte(8'h0A); wait_idle(n); end
    for (int k = 0; k < 3; k++) begin send_byte(8'h55); wait_idle(n); end
    bd_mode = 2;
    for (int i = 0; i < 2400; i++) model_mem[i] = 8'(i / 80 + 1);
    step();
    bd_mode = 0;
    send_byte(8'h0A);
`ifdef TEXT_CONSOLE_SCROLL_EN
    exp_n = 4720;
`else
    exp_n = 80;
`endif
    wait_idle(n);
    checks++; if (n != exp_n) begin failures++; $display("FAIL scroll_cycles got=%0d exp=%0d", n, exp_n); end
    checks++; if ({cursor_row, cursor_col} !== {5'(model_row), 7'(model_col)}) begin
      failures++; $display("FAIL scroll_cursor got=(%0d,%0d) exp=(%0d,%0d)", cursor_row, cursor_col, model_row, model_col); end
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL scroll_ram diffs=%0d first=%0d got=%h exp=%h", d, first, mem[first], model_mem[first]); end
  endtask

  task automatic test_random();
    int n, r, bad, first, d;
    logic [7:0] b;
    send_byte(8'h0C);
    wait_idle(n);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 6) b = 8'h0A;
      else if (r < 10) b = 8'h0D;
      else if (r < 18) b = 8'h08;
      else if (r < 19) b = 8'h0C;
      else b = 8'($urandom_range(0, 255));
      send_byte(b);
      wait_idle(n);
      if ({cursor_row, cursor_col} !== {5'(model_row), 7'(model_col)}) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL random_cursor bad_steps=%0d exp=0", bad); end
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL random_ram diffs=%0d first=%0d got=%h exp=%h", d, first, mem[first], model_mem[first]); end
  endtask

  task automatic test_reset_mid();
    int n, first, d;
`ifdef TEXT_CONSOLE_SCROLL_EN
    send_byte(8'h0D);
    wait_idle(n);
    while (model_row < 29) begin send_byte(8'h0A); wait_idle(n); end
    send_byte(8'h0A);
`else
    send_byte(8'h0C);
`endif
    repeat (1000) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if ({tram_wenable, busy, char_ready, tram_addr} !== {1'b0, 1'b0, 1'b1, 12'd0}) begin
      failures++; $display("FAIL midrst_out got=we%b busy%b rdy%b a%0d exp=we0 busy0 rdy1 a0", tram_wenable, busy, char_ready, tram_addr); end
    checks++; if ({cursor_row, cursor_col} !== 12'd0) begin failures++; $display("FAIL midrst_cursor got=(%0d,%0d) exp=(0,0)", cursor_row, cursor_col); end
    step();
    step();
    rst_n = 1'b1;
    model_row = 0;
    model_col = 0;
    send_byte(8'h5A);
    checks++; if ({tram_wenable, tram_addr, tram_wdata} !== {1'b1, 12'd0, 8'h5A}) begin
      failures++; $display("FAIL post_rst_write got=we%b a%0d d%h exp=we1 a0 d5a", tram_wenable, tram_addr, tram_wdata); end
    wait_idle(n);
    checks++; if ({cursor_row, cursor_col} !== {5'd0, 7'd1}) begin failures++; $display("FAIL post_rst_cursor got=(%0d,%0d) exp=(0,1)", cursor_row, cursor_col); end
    send_byte(8'h0C);
    wait_idle(n);
    d = ram_diffs(first);
    checks++; if (d != 0) begin failures++; $display("FAIL post_rst_ram diffs=%0d first=%0d", d, first); end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_row_fill();
    test_clear();
    test_backspace();
    test_back_to_back();
    test_scroll();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
